// File: rtl/food_placer.sv
// Food placement for the snake playfield: draws LFSR candidates, rejects those that
// land on the body during one traversal, and pulses o_eat when the head reaches the food.
module food_placer #(
    parameter int          X_MIN = 1,
    parameter int          X_MAX = 20,
    parameter int          Y_MIN = 1,
    parameter int          Y_MAX = 14,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_pos_x,
    input  logic [3:0] i_pos_y,
    input  logic       i_pos_first,
    input  logic       i_pos_last,
    input  logic       i_pos_valid,
    input  logic       i_failure,
    output logic       o_eat,
    output logic [4:0] o_food_x,
    output logic [3:0] o_food_y,
    output logic       o_food_valid
);

    typedef enum logic [1:0] {
        PICK   = 2'd0,
        CHECK  = 2'd1,
        PLACED = 2'd2
    } state_t;

    state_t      state_reg;
    logic [15:0] lfsr_reg;
    logic        clash_reg;
    logic        armed_reg;

    logic        lfsr_fb;
    logic [4:0]  cand_x;
    logic [3:0]  cand_y;
    logic        cand_ok;
    logic        pos_match;
    logic        arm_now;
    logic        armed_now;
    logic        clash_now;

    // Right-shifting Fibonacci LFSR, taps 16,14,13,11 counted from the output end.
    assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[2] ^ lfsr_reg[3] ^ lfsr_reg[5];
    assign cand_x  = lfsr_reg[4:0];
    assign cand_y  = lfsr_reg[11:8];
    assign cand_ok = (int'(cand_x) >= X_MIN) && (int'(cand_x) <= X_MAX) &&
                     (int'(cand_y) >= Y_MIN) && (int'(cand_y) <= Y_MAX);

    assign pos_match = i_pos_valid && (i_pos_x == o_food_x) && (i_pos_y == o_food_y);
    assign arm_now   = i_pos_valid && i_pos_first;
    // The arming head sample itself already takes part in the clash test.
    assign armed_now = armed_reg || arm_now;
    assign clash_now = clash_reg || (armed_now && pos_match);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= PICK;
            lfsr_reg     <= SEED;
            clash_reg    <= 1'b0;
            armed_reg    <= 1'b0;
            o_eat        <= 1'b0;
            o_food_x     <= 5'd0;
            o_food_y     <= 4'd0;
            o_food_valid <= 1'b0;
        end else begin
            lfsr_reg <= {lfsr_fb, lfsr_reg[15:1]};
            o_eat    <= 1'b0;
            if (!i_failure) begin
                case (state_reg)
                    PICK: begin
                        if (cand_ok) begin
                            o_food_x  <= cand_x;
                            o_food_y  <= cand_y;
                            clash_reg <= 1'b0;
                            armed_reg <= 1'b0;
                            state_reg <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (armed_now && i_pos_valid && i_pos_last) begin
                            if (clash_now) begin
                                state_reg <= PICK;
                            end else begin
                                o_food_valid <= 1'b1;
                                state_reg    <= PLACED;
                            end
                        end else begin
                            armed_reg <= armed_now;
                            clash_reg <= clash_now;
                        end
                    end
                    PLACED: begin
                        if (arm_now && pos_match) begin
                            o_eat        <= 1'b1;
                            o_food_valid <= 1'b0;
                            state_reg    <= PICK;
                        end
                    end
                    default: state_reg <= PICK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: a cycle model of the placement rules checked against the DUT
// every cycle, plus directed stream frames with hand-computed expectations.
module tb_food_placer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] pos_x = 5'd0;
    logic [3:0] pos_y = 4'd0;
    logic       pos_first = 1'b0;
    logic       pos_last = 1'b0;
    logic       pos_valid = 1'b0;
    logic       failure = 1'b0;
    logic       o_eat;
    logic [4:0] o_food_x;
    logic [3:0] o_food_y;
    logic       o_food_valid;

    int n_vec = 0;
    int n_bad = 0;

    localparam int M_PICK = 0, M_CHECK = 1, M_PLACED = 2;

    // Model of what the outputs must be after the most recent clock edge.
    logic [15:0] m_lfsr;
    int          m_mode;
    bit          m_seen, m_hit, m_eat, m_fv;
    int          m_fx, m_fy;
    bit          m_known = 1'b0;

    food_placer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pos_x      (pos_x),
        .i_pos_y      (pos_y),
        .i_pos_first  (pos_first),
        .i_pos_last   (pos_last),
        .i_pos_valid  (pos_valid),
        .i_failure    (failure),
        .o_eat        (o_eat),
        .o_food_x     (o_food_x),
        .o_food_y     (o_food_y),
        .o_food_valid (o_food_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        int b;
        b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (b << 15));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int cx, cy;
        bit match;
        if (!rst_n) begin
            m_lfsr = 16'hACE1; m_mode = M_PICK; m_seen = 0; m_hit = 0;
            m_eat = 0; m_fv = 0; m_fx = 0; m_fy = 0; m_known = 1;
        end else begin
            m_eat = 0;
            match = pos_valid && (int'(pos_x) == m_fx) && (int'(pos_y) == m_fy);
            if (!failure) begin
                if (m_mode == M_PICK) begin
                    cx = int'(m_lfsr & 16'h001F);
                    cy = int'((m_lfsr >> 8) & 16'h000F);
                    if (cx >= 1 && cx <= 20 && cy >= 1 && cy <= 14) begin
                        m_fx = cx; m_fy = cy; m_seen = 0; m_hit = 0; m_mode = M_CHECK;
                    end
                end else if (m_mode == M_CHECK) begin
                    if (pos_valid) begin
                        if (pos_first) m_seen = 1;
                        if (m_seen && match) m_hit = 1;
                        if (m_seen && pos_last) begin
                            if (m_hit) m_mode = M_PICK;
                            else begin m_fv = 1; m_mode = M_PLACED; end
                        end
                    end
                end else begin
                    if (pos_valid && pos_first && match) begin
                        m_eat = 1; m_fv = 0; m_mode = M_PICK;
                    end
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // Compare, then advance the model with the inputs the next edge will sample.
    initial begin
        forever begin
            @(negedge clk);
            if (m_known) begin
                check("cyc_eat", o_eat, m_eat);
                check("cyc_food_x", o_food_x, m_fx);
                check("cyc_food_y", o_food_y, m_fy);
                check("cyc_food_valid", o_food_valid, m_fv);
            end
            model_step();
        end
    end

    task automatic seg(input int x, input int y, input bit f, input bit l);
        pos_x = 5'(x); pos_y = 4'(y); pos_first = f; pos_last = l; pos_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        pos_valid = 1'b0; pos_first = 1'b0; pos_last = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_mode(input int want);
        for (int i = 0; i < 100 && m_mode != want; i++) idle();
        n_vec++;
        if (m_mode != want) begin
            n_bad++;
            $display("FAIL wait_mode: mode %0d, wanted %0d within 100 cycles", m_mode, want);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, x, y, fx, fy;
        rst_n = 1'b0;
        repeat (3) idle();
        check("rst_eat", o_eat, 0);
        check("rst_food_x", o_food_x, 0);
        check("rst_food_y", o_food_y, 0);
        check("rst_food_valid", o_food_valid, 0);

        // First candidate from 16'hACE1 is (1,12), inside the field.
        rst_n = 1'b1;
        idle();
        check("model_lfsr_one_shift", m_lfsr, 16'h5670);
        check("first_food_x", o_food_x, 1);
        check("first_food_y", o_food_y, 12);
        check("first_food_valid", o_food_valid, 0);

        // Clean traversal: head (10,5), body (3,3), tail (10,6).
        idle();
        seg(10, 5, 1, 0);
        seg(3, 3, 0, 0);
        seg(10, 6, 0, 1);
        check("placed_valid", o_food_valid, 1);
        check("placed_eat", o_eat, 0);

        // Body segment on the food must not eat.
        seg(10, 5, 1, 0);
        seg(1, 12, 0, 0);
        check("body_on_food_eat", o_eat, 0);
        seg(10, 6, 0, 1);
        check("body_on_food_valid", o_food_valid, 1);

        // Head on food while failure is asserted: no eat, food stays.
        failure = 1'b1;
        seg(1, 12, 1, 0);
        check("fail_eat", o_eat, 0);
        check("fail_valid", o_food_valid, 1);
        seg(10, 6, 0, 1);
        failure = 1'b0;

        // Head on food: one-cycle eat, valid drops with it.
        seg(1, 12, 1, 0);
        check("eat_pulse", o_eat, 1);
        check("eat_valid_low", o_food_valid, 0);
        seg(10, 6, 0, 1);
        check("eat_width", o_eat, 0);

        // Tail on the new candidate: clash, valid never rises.
        wait_mode(M_CHECK);
        fx = m_fx; fy = m_fy;
        seg(10, 5, 1, 0);
        seg(fx, fy, 0, 1);
        check("clash_valid", o_food_valid, 0);
        idle();
        check("clash_valid_after", o_food_valid, 0);

        // Single segment that is both head and tail, off the food.
        wait_mode(M_CHECK);
        seg(0, 0, 1, 1);
        check("single_seg_valid", o_food_valid, 1);
        seg(m_fx, m_fy, 1, 0);
        check("single_eat", o_eat, 1);

        // Single segment on the food clashes in the same cycle.
        wait_mode(M_CHECK);
        seg(m_fx, m_fy, 1, 1);
        check("single_clash_valid", o_food_valid, 0);

        // Reset during CHECK.
        wait_mode(M_CHECK);
        seg(10, 5, 1, 0);
        rst_n = 1'b0;
        seg(3, 3, 0, 0);
        check("rst_check_food_x", o_food_x, 0);
        check("rst_check_food_y", o_food_y, 0);
        rst_n = 1'b1;

        // Reset in PLACED on the same cycle as a head match: no eat.
        idle();
        check("rerun_food_x", o_food_x, 1);
        seg(0, 0, 1, 1);
        check("rerun_valid", o_food_valid, 1);
        rst_n = 1'b0;
        seg(1, 12, 1, 0);
        check("rst_placed_eat", o_eat, 0);
        check("rst_placed_valid", o_food_valid, 0);
        rst_n = 1'b1;
        idle();
        check("rst_placed_eat_after", o_eat, 0);

        // Mixed frames with hits on the food, failure pulses and rare resets.
        for (int fr = 0; fr < 300; fr++) begin
            len = $urandom_range(1, 6);
            for (int s = 0; s < len; s++) begin
                failure = ($urandom_range(0, 15) == 0);
                if ($urandom_range(0, 2) == 0) begin
                    x = m_fx; y = m_fy;
                end else begin
                    x = $urandom_range(0, 24); y = $urandom_range(0, 15);
                end
                seg(x, y, s == 0, s == len - 1);
            end
            failure = 1'b0;
            repeat ($urandom_range(0, 3)) idle();
            if ($urandom_range(0, 99) == 0) begin
                rst_n = 1'b0;
                idle();
                rst_n = 1'b1;
            end
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/food_placer.md
# food_placer

Places the food item on the playfield and detects when the snake eats it. The block consumes the per-cycle body-segment stream (position, first/last/valid flags) produced by the snake traversal stage. It draws pseudo-random candidates, rejects any that overlap the body, and drives the single-cycle eat pulse back into the snake stage's length counter.

## Interface

Parameters:
- X_MIN, default 1, lowest legal food column
- X_MAX, default 20, highest legal food column
- Y_MIN, default 1, lowest legal food row
- Y_MAX, default 14, highest legal food row
- SEED, default 16'hACE1, LFSR reset value (must be non-zero)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_pos_x  in  5  column of the current body segment
- i_pos_y  in  4  row of the current body segment
- i_pos_first  in  1  current segment is the head
- i_pos_last  in  1  current segment is the tail
- i_pos_valid  in  1  current segment is part of the snake
- i_failure  in  1  game-over indication from the snake stage
- o_eat  out  1  one-cycle pulse: head is on the food
- o_food_x  out  5  food column
- o_food_y  out  4  food row
- o_food_valid  out  1  food is placed and displayable

## Operation

- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle including while frozen; reset to SEED.
- Candidate: x = lfsr[4:0], y = lfsr[11:8]. Accepted only if X_MIN ≤ x ≤ X_MAX and Y_MIN ≤ y ≤ Y_MAX; otherwise discarded and redrawn next cycle.
- FSM states:
  - PICK: on an accepted candidate, latch it into o_food_x/o_food_y, clear clash and armed, and go to CHECK. Otherwise stay.
  - CHECK: set armed on a cycle with i_pos_valid && i_pos_first. While armed, or in the arming cycle itself, each cycle with i_pos_valid and pos == food sets clash.
    - On the first armed cycle with i_pos_valid && i_pos_last, where the comparison of that same cycle is included: if clash, go to PICK; else set o_food_valid=1 and go to PLACED.
    - A segment that is both first and last is compared, and the decision is taken in that cycle.
  - PLACED: on i_pos_valid && i_pos_first && pos == food, assert o_eat for the next cycle, clear o_food_valid, and go to PICK. Non-head segments matching the food never trigger eat.
- i_failure high: FSM holds its state; o_eat is forced 0; o_food_x/y/valid hold. Normal operation resumes when i_failure drops.
- Cycles with i_pos_valid=0 are ignored for comparison and flags.

## Timing

- Reset values: o_eat=0, o_food_x=0, o_food_y=0, o_food_valid=0, state=PICK, clash=0, armed=0, lfsr=SEED.
- All outputs are registered. o_eat rises exactly one cycle after the matching head sample and lasts exactly 1 cycle.
- o_food_valid rises one cycle after the tail sample that closes a clean CHECK.
- o_food_valid falls in the same cycle o_eat rises.
- Placement latency: PICK time plus at most two full traversals (≤ 2×220 cycles) after acceptance. A clash costs one additional traversal plus redraw.
- Only one eat per traversal: the head appears once per 220-cycle frame.
- rst_n low mid-CHECK or mid-PLACED: next cycle shows reset values; no o_eat pulse is emitted from a pending match.
- i_failure asserted in the same cycle as the head match: no eat; the state remains PLACED.

## Test plan

- Reset, then sample: all outputs 0, state PICK. LFSR value after 1 cycle equals one shift of 16'hACE1.
- Force an LFSR candidate x=7, y=3 and a stream of head (10,5) plus tail (10,6) -> o_food_valid=1 and food=(7,3) after the first full traversal; o_eat stays 0.
- Candidate (10,6) matching the tail segment -> clash, return to PICK, new candidate drawn. o_food_valid never rises for (10,6).
- Food at (7,3) in PLACED, head sample (7,3) valid+first -> o_eat=1 for exactly one cycle and o_food_valid=0 that cycle. A non-head segment at (7,3) produces no pulse.
- i_failure=1 while the head matches the food -> o_eat=0, o_food_valid stays 1. Drop i_failure; the next head match pulses o_eat.
- Candidate x=25 (out of range) -> rejected, no state change. Assert rst_n=0 during CHECK -> outputs return to reset values the following cycle.
